mem_responder: RTL

//  Memory-side end of the core memory interface (mem_read/mem_write/mem_byte_enable/
//  mem_address/mem_wdata -> mem_resp/mem_rdata). Word-addressed synthesizable RAM with

---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : core-to-memory request/response bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : word-addressed RAM with fixed response latency, byte-enabled
//                 writes, protocol-error flag and access counters
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_responder_if.slave   bus,
  output logic             proto_err,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
);

  localparam int         DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_t;

  logic [31:0] mem [DEPTH];

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;

  // Byte-offset and aliased upper address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_address[31:ADDR_WIDTH+2], bus.mem_address[1:0]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          addr_d  = bus.mem_address[ADDR_WIDTH+1:2];
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
          if (bus.mem_read && bus.mem_write) begin
            op_d  = OP_ERR;
            err_d = 1'b1;
          end else if (bus.mem_write) begin
            op_d  = OP_WR;
          end else begin
            op_d  = OP_RD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (op_q == OP_RD) begin
            rdata_d = mem[addr_q];
          end else if (op_q == OP_ERR) begin
            rdata_d = 32'd0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (op_q == OP_RD) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end else if (op_q == OP_WR) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_RD;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Commit happens on the closing edge of RESP so a reset there abandons the write.
  always_ff @(posedge clk) begin
    if (rst && (state_q == S_RESP) && (op_q == OP_WR)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_resp  = (state_q == S_RESP);
  assign bus.mem_rdata = rdata_q;
  assign proto_err     = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

`default_nettype wire
